// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryption core: recovers the final round key with the forward
// schedule, then unwinds one inverse round per clock while stepping the key schedule back.
module present_decrypt #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [63:0] idat,
    input  logic [79:0] key,
    output logic [63:0] odat,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEYEXP  = 2'd1,
        DECRYPT = 2'd2
    } fsm_t;

    localparam logic [4:0] LAST = 5'(ROUNDS);

    fsm_t        fsm_q, fsm_d;
    logic [63:0] state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] odat_q, odat_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [79:0] rot;
    logic [79:0] fwd_key;
    logic [79:0] undo;
    logic [79:0] inv_key;
    logic [63:0] inv_state;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sinv_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[6'(4 * n) +: 4] = sbox_inv(x[6'(4 * n) +: 4]);
        end
        return y;
    endfunction

    // Inverse bit permutation: output bit i is taken from input bit 16*i mod 63.
    function automatic logic [63:0] pinv_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[6'(i)] = x[6'((16 * i) % 63)];
        end
        y[63] = x[63];
        return y;
    endfunction

    always_comb begin
        rot     = {key_q[18:0], key_q[79:19]};
        fwd_key = {sbox(rot[79:76]), rot[75:20], rot[19:15] ^ cnt_q, rot[14:0]};

        // Undo the counter xor and top-nibble S-box, then rotate back by 61.
        undo          = key_q;
        undo[79:76]   = sbox_inv(key_q[79:76]);
        undo[19:15]   = key_q[19:15] ^ cnt_q;
        inv_key       = {undo[60:0], undo[79:61]};
        inv_state     = sinv_layer(pinv_layer(state_q)) ^ inv_key[79:16];

        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        odat_d  = odat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (load) begin
            state_d = idat;
            key_d   = key;
            cnt_d   = 5'd1;
            busy_d  = 1'b1;
            fsm_d   = KEYEXP;
        end else begin
            case (fsm_q)
                KEYEXP: begin
                    key_d = fwd_key;
                    if (cnt_q == LAST) begin
                        state_d = state_q ^ fwd_key[79:16];
                        cnt_d   = LAST;
                        fsm_d   = DECRYPT;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                DECRYPT: begin
                    key_d   = inv_key;
                    state_d = inv_state;
                    if (cnt_q == 5'd1) begin
                        odat_d = inv_state;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                        fsm_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            odat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            odat_q  <= odat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign odat = odat_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_present_decrypt.sv
// Directed bench for present_decrypt using the published PRESENT-80 test vectors.
module tb_present_decrypt;

    logic        clk;
    logic        reset;
    logic        load;
    logic [63:0] idat;
    logic [79:0] key;
    logic [63:0] odat;
    logic        busy;
    logic        done;

    int pass_cnt;
    int total_cnt;

    localparam logic [79:0] K0   = 80'h0;
    localparam logic [79:0] KF   = 80'hffff_ffff_ffff_ffff_ffff;
    localparam logic [63:0] P0   = 64'h0;
    localparam logic [63:0] PF   = 64'hffff_ffff_ffff_ffff;
    localparam logic [63:0] C_00 = 64'h5579c1387b228445;
    localparam logic [63:0] C_F0 = 64'he72c46c0f5945049;
    localparam logic [63:0] C_0F = 64'ha112ffc72f68417b;
    localparam logic [63:0] C_FF = 64'h3333dcd3213210d2;

    present_decrypt #(.ROUNDS(31)) dut (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .idat (idat),
        .key  (key),
        .odat (odat),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; the load edge is the next posedge, returns at the following negedge.
    task automatic do_load(input logic [63:0] d, input logic [79:0] k);
        idat = d;
        key  = k;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Counts edges after the load edge until done; busy must stay high until then.
    task automatic wait_done(input int limit, output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load  = 1'b0;
        idat  = '0;
        key   = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({odat, busy, done} !== 66'h0) $display("FAIL reset_outputs: odat=%h busy=%b done=%b, required all 0", odat, busy, done);
        else pass_cnt++;
        total_cnt++;
        if (dut.cnt_q !== 5'd0 || dut.key_q !== 80'h0) $display("FAIL reset_regs: cnt=%0d key=%h, required 0", dut.cnt_q, dut.key_q);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vector(input logic [63:0] ct, input logic [79:0] k, input logic [63:0] pt, input string name);
        int lat;
        bit bok;
        do_load(ct, k);
        wait_done(100, lat, bok);
        total_cnt++;
        if (lat !== 62) $display("FAIL %s_latency: got %0d cycles, required 62", name, lat);
        else pass_cnt++;
        total_cnt++;
        if (odat !== pt) $display("FAIL %s_odat: got %h, required %h", name, odat, pt);
        else pass_cnt++;
        total_cnt++;
        if (bok !== 1'b1) $display("FAIL %s_busy: busy profile wrong, got flag %b, required 1", name, bok);
        else pass_cnt++;
        total_cnt++;
        if (dut.key_q !== k) $display("FAIL %s_final_key: got %h, required %h", name, dut.key_q, k);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s_pulse: done=%b busy=%b, required 0 0", name, done, busy);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (odat !== pt) $display("FAIL %s_hold: got %h, required %h", name, odat, pt);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int lat;
        bit bok;
        do_load(C_0F, K0);
        repeat (19) @(negedge clk);
        do_load(C_F0, KF);
        wait_done(100, lat, bok);
        total_cnt++;
        if (lat !== 62) $display("FAIL abort_latency: got %0d cycles, required 62", lat);
        else pass_cnt++;
        total_cnt++;
        if (odat !== P0) $display("FAIL abort_odat: got %h, required %h", odat, P0);
        else pass_cnt++;
        total_cnt++;
        if (bok !== 1'b1) $display("FAIL abort_busy: flag %b, required 1", bok);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bok;
        int dones;
        do_load(C_0F, K0);
        wait_done(100, lat, bok);
        total_cnt++;
        if (odat !== PF) $display("FAIL rstmid_pre_odat: got %h, required %h", odat, PF);
        else pass_cnt++;
        @(negedge clk);
        do_load(C_FF, KF);
        repeat (39) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total_cnt++;
        if ({odat, busy, done} !== 66'h0) $display("FAIL rstmid_outputs: odat=%h busy=%b done=%b, required all 0", odat, busy, done);
        else pass_cnt++;
        total_cnt++;
        if (dut.cnt_q !== 5'd0) $display("FAIL rstmid_cnt: got %0d, required 0", dut.cnt_q);
        else pass_cnt++;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL rstmid_quiet: %0d active cycles after reset, required 0", dones);
        else pass_cnt++;
        // Reset and load in the same cycle: reset wins.
        reset = 1'b1;
        idat  = C_FF;
        key   = KF;
        load  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        total_cnt++;
        if ({odat, busy, done} !== 66'h0) $display("FAIL rstload_outputs: odat=%h busy=%b done=%b, required all 0", odat, busy, done);
        else pass_cnt++;
        total_cnt++;
        if (dut.key_q !== 80'h0 || dut.state_q !== 64'h0) $display("FAIL rstload_regs: key=%h state=%h, required 0", dut.key_q, dut.state_q);
        else pass_cnt++;
        dones = 0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL rstload_quiet: %0d active cycles, required 0", dones);
        else pass_cnt++;
        test_vector(C_FF, KF, PF, "post_reset");
    endtask

    task automatic test_back_to_back();
        logic [63:0] cts [4];
        logic [79:0] kys [4];
        logic [63:0] pts [4];
        int lat;
        bit bok;
        cts = '{C_00, C_FF, C_0F, C_F0};
        kys = '{K0, KF, K0, KF};
        pts = '{P0, PF, PF, P0};
        do_load(cts[0], kys[0]);
        for (int i = 0; i < 4; i++) begin
            wait_done(100, lat, bok);
            total_cnt++;
            if (lat !== 62) $display("FAIL b2b%0d_latency: got %0d cycles, required 62", i, lat);
            else pass_cnt++;
            total_cnt++;
            if (odat !== pts[i]) $display("FAIL b2b%0d_odat: got %h, required %h", i, odat, pts[i]);
            else pass_cnt++;
            if (i < 3) do_load(cts[i + 1], kys[i + 1]);
            else @(negedge clk);
        end
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_end: done=%b busy=%b, required 0 0", done, busy);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_vector(C_00, K0, P0, "k0_p0");
        test_vector(C_F0, KF, P0, "kf_p0");
        test_vector(C_FF, KF, PF, "kf_pf");
        test_vector(C_0F, K0, PF, "k0_pf");
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/present_decrypt.md
Name: present_decrypt

Overview:
Iterative PRESENT-80 decryption core, the inverse of the team's PRESENT encryption module. It latches a 64-bit ciphertext and the 80-bit user key on a load strobe. It then runs the forward key schedule to recover the final round key, and unwinds 31 inverse rounds one per clock. It sits beside the encrypt core and uses the same load-and-wait style of interface.

Parameters:
ROUNDS, 31, number of cipher rounds. Must be 31 for PRESENT compliance; other values are for debug only.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
load  input  1  one-cycle strobe; captures idat and key and starts an operation
idat  input  64  ciphertext input
key  input  80  PRESENT-80 user key (same bit order as the encrypt core)
odat  output  64  plaintext; valid from the done cycle until the next load or reset
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when odat holds the new plaintext

Behaviour:
- Reset (synchronous, active-high):
  - odat, busy and done go to 0.
  - FSM goes to IDLE.
  - The round counter and internal state/key registers clear to 0.
  - Reset has priority over load in the same cycle.
- FSM states: IDLE -> KEYEXP -> DECRYPT -> IDLE.
- load=1 in any state:
  - state_reg <= idat, key_reg <= key, cnt <= 1, busy <= 1, done <= 0.
  - FSM goes to KEYEXP.
  - A load while busy aborts the current operation and restarts. No done is issued for the aborted operation.
- KEYEXP, one cycle per cnt = 1..ROUNDS (forward key update):
  - key_reg <= { S(rot[79:76]), rot[75:20], rot[19:15] ^ cnt[4:0], rot[14:0] }, where rot = key_reg rotated left by 61.
  - On the cnt == ROUNDS cycle, also whiten: state_reg <= state_reg ^ next_key[79:16] (this is K32).
  - Then cnt <= ROUNDS and the FSM goes to DECRYPT.
- DECRYPT, one cycle per cnt = ROUNDS down to 1 (inverse key update):
  - Undo the counter: u = key_reg with u[19:15] = key_reg[19:15] ^ cnt.
  - Undo the S-box: u[79:76] = Sinv(key_reg[79:76]).
  - Rotate: next_key = u rotated right by 61 (equivalently left by 19).
  - key_reg <= next_key.
  - state_reg <= Sinv(Pinv(state_reg)) ^ next_key[79:16].
  - Pinv: bit j of the input moves to position i, where j = 16*i mod 63 for i < 63, and bit 63 is fixed.
  - Sinv is applied nibble-wise on all 16 nibbles.
  - On the cnt == 1 cycle: odat <= next state, done <= 1 for one cycle, busy <= 0, FSM goes to IDLE.
- Latency: 2*ROUNDS = 62 cycles from the load edge to the edge that raises done.
- After the final round, key_reg equals the user key; a bench may check this through hierarchy.
- odat holds its value in IDLE and changes only at done or reset.
- Tables:
  - S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
  - Sinv = 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A
- Counter is 5 bits, with no wrap: cnt never leaves the range 1..31 while busy.

Test Plan:
1. key=0, idat=64'h5579c1387b228445, pulse load -> done exactly 62 cycles later, odat=64'h0000000000000000, busy high throughout.
2. key=80'hffff_ffffffffffffffff, idat=64'he72c46c0f5945049 -> odat=64'h0000000000000000. Then idat=64'h3333dcd3213210d2 -> odat=64'hffffffffffffffff.
3. key=0, idat=64'ha112ffc72f68417b -> odat=64'hffffffffffffffff. Also loopback: encrypt core output fed to this block reproduces all 25 plaintext/key pairs of the encrypt bench.
4. Load issued at cycle 20 of an operation with new data (vector 2) -> no done for the first operation; done 62 cycles after the second load with the correct plaintext.
5. Reset asserted mid-DECRYPT, and reset asserted together with load -> odat/busy/done = 0 on the next edge, FSM in IDLE, no done pulse; a subsequent load completes normally.
6. Back-to-back loads on consecutive done cycles -> each operation produces exactly one done pulse and the correct odat.
